// File: rtl/fir_pkg.sv
// fir_pkg: shared types, widths and helpers for the FIR sample feeder.
package fir_pkg;
  localparam int FIR_WIDTH = 16;
  typedef enum logic [1:0] {WAIT_READY, HAVE_CREDIT, ISSUE} feeder_state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/fir_feed_fifo.sv
// fir_feed_fifo: synchronous FIFO with registered full/empty/level and flush.
module fir_feed_fifo
  import fir_pkg::*;
#(
  parameter int WIDTH = FIR_WIDTH,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  level
);
  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] level_nxt;
  logic do_push, do_pop;
  assign do_push = wr_en && !full && !flush;
  assign do_pop = rd_en && !empty;
  assign level_nxt = level + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wr_data;
  // A flush still lets the coincident pop read the head; the pointers are simply reset.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      level <= level_nxt;
      full <= level_nxt == FULL_LVL;
      empty <= level_nxt == '0;
    end
endmodule

// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: buffers upstream samples and issues one per FIR ready pulse.
module fir_sample_feeder
  import fir_pkg::*;
#(
  parameter int WIDTH = FIR_WIDTH,
  parameter int DEPTH = 16,
  parameter int START_CREDIT = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   flush,
  input  logic                   ready_for_input,
  output logic [WIDTH-1:0]       FIR_input,
  output logic                   input_valid,
  output logic [clog2(DEPTH):0]  level,
  output logic [31:0]            issued_count,
  output logic                   err_proto,
  input  logic                   err_clr
);
  localparam feeder_state_t RST_STATE = (START_CREDIT != 0) ? HAVE_CREDIT : WAIT_READY;
  feeder_state_t state;
  logic full, empty, pop, proto_err;
  logic [WIDTH-1:0] head;
  assign s_ready = !full;
  assign pop = !empty && ((state == WAIT_READY && ready_for_input) || state == HAVE_CREDIT);
  // A ready pulse outside WAIT_READY would mean a second credit; it is flagged and dropped.
  assign proto_err = ready_for_input && state != WAIT_READY;
  fir_feed_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .wr_en(s_valid),
    .wr_data(s_data),
    .rd_en(pop),
    .rd_data(head),
    .full(full),
    .empty(empty),
    .level(level)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= RST_STATE;
      FIR_input <= '0;
      input_valid <= 1'b0;
      issued_count <= '0;
      err_proto <= 1'b0;
    end else begin
      state <= pop ? ISSUE : state == ISSUE ? WAIT_READY :
               (state == WAIT_READY && ready_for_input) ? HAVE_CREDIT : state;
      input_valid <= pop;
      if (pop) FIR_input <= head;
      issued_count <= issued_count + 32'(state == ISSUE);
      err_proto <= proto_err || (err_proto && !err_clr);
    end
endmodule

// File: tb/tb_fir_sample_feeder.sv
// tb_fir_sample_feeder: directed and random checks against a queue/credit reference model.
module tb_fir_sample_feeder;
  localparam int DEPTH = 16;
  logic clk = 0;
  logic reset = 0;
  logic [15:0] s_data = 0;
  logic s_valid = 0, flush = 0, ready_for_input = 0, err_clr = 0;
  logic s_ready, input_valid, err_proto;
  logic [15:0] FIR_input;
  logic [4:0] level;
  logic [31:0] issued_count;
  logic reset2 = 0;
  logic [15:0] s2_data = 0;
  logic s2_valid = 0, flush2 = 0, rfi2 = 0, err_clr2 = 0;
  logic s2_ready, valid2, err2;
  logic [15:0] fir2;
  logic [4:0] level2;
  logic [31:0] count2;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  fir_sample_feeder #(.WIDTH(16), .DEPTH(DEPTH), .START_CREDIT(0)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .flush(flush), .ready_for_input(ready_for_input), .FIR_input(FIR_input),
    .input_valid(input_valid), .level(level), .issued_count(issued_count),
    .err_proto(err_proto), .err_clr(err_clr));

  fir_sample_feeder #(.WIDTH(16), .DEPTH(DEPTH), .START_CREDIT(1)) dut_sc (
    .clk(clk), .reset(reset2), .s_data(s2_data), .s_valid(s2_valid), .s_ready(s2_ready),
    .flush(flush2), .ready_for_input(rfi2), .FIR_input(fir2),
    .input_valid(valid2), .level(level2), .issued_count(count2),
    .err_proto(err2), .err_clr(err_clr2));

  // Reference model: a sample queue plus at most one outstanding issue credit.
  logic [15:0] q[$];
  bit credit, m_valid, m_err, acc;
  logic [15:0] m_fir;
  int unsigned m_count;

  always @(posedge clk or negedge reset)
    if (!reset) begin
      q.delete();
      credit = 0;
      m_valid = 0;
      m_err = 0;
      m_fir = 0;
      m_count = 0;
    end else begin
      acc = s_valid && q.size() < DEPTH && !flush;
      if (ready_for_input && (m_valid || credit)) m_err = 1;
      else if (err_clr) m_err = 0;
      if (m_valid) begin
        m_valid = 0;
        m_count++;
      end else begin
        if (ready_for_input) credit = 1;
        if (credit && q.size() > 0) begin
          m_fir = q.pop_front();
          m_valid = 1;
          credit = 0;
        end
      end
      if (flush) q.delete();
      else if (acc) q.push_back(s_data);
    end

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (FIR_input !== 0 || input_valid !== 0 || level !== 0 || issued_count !== 0 ||
        err_proto !== 0 || s_ready !== 1) begin
      n_fail++;
      $display("FAIL reset_state: fir=%h valid=%b level=%0d cnt=%0d err=%b s_ready=%b (want 0,0,0,0,0,1)",
               FIR_input, input_valid, level, issued_count, err_proto, s_ready);
    end
    reset = 1;
  endtask

  task automatic test_in_order();
    for (int k = 0; k < 3; k++) begin
      s_valid = 1;
      s_data = 16'(k + 1);
      @(negedge clk);
      n_checks++;
      if (level !== 5'(k + 1)) begin
        n_fail++;
        $display("FAIL push_level: got %0d want %0d", level, k + 1);
      end
    end
    s_valid = 0;
    for (int p = 0; p < 3; p++)
      for (int c = 0; c < 70; c++) begin
        ready_for_input = (c == 0);
        @(negedge clk);
        ready_for_input = 0;
        n_checks++;
        if (input_valid !== m_valid || FIR_input !== m_fir || level !== 5'(q.size()) ||
            issued_count !== m_count || input_valid !== (c == 0) ||
            (c == 0 && FIR_input !== 16'(p + 1))) begin
          n_fail++;
          $display("FAIL in_order p%0d c%0d: valid=%b/%b fir=%h/%h level=%0d/%0d cnt=%0d/%0d",
                   p, c, input_valid, m_valid, FIR_input, m_fir, level, q.size(), issued_count, m_count);
        end
      end
    n_checks++;
    if (issued_count !== 3 || level !== 0) begin
      n_fail++;
      $display("FAIL in_order_end: cnt=%0d level=%0d want 3,0", issued_count, level);
    end
  endtask

  task automatic test_empty_credit();
    repeat (2) @(negedge clk);
    for (int i = 0; i <= 10; i++) begin
      ready_for_input = (i == 0);
      s_valid = (i == 5);
      s_data = 16'h00AB;
      @(negedge clk);
      ready_for_input = 0;
      s_valid = 0;
      n_checks++;
      if (input_valid !== m_valid || FIR_input !== m_fir || input_valid !== (i == 6) ||
          (i == 6 && FIR_input !== 16'h00AB)) begin
        n_fail++;
        $display("FAIL empty_credit i%0d: valid=%b/%b fir=%h/%h", i, input_valid, m_valid, FIR_input, m_fir);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got[$];
    int idx = 0;
    bit sr, saw_full = 0;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 600 && got.size() < 20; c++) begin
      s_valid = idx < 20;
      s_data = 16'h0100 + 16'(idx);
      ready_for_input = c >= 24 && !m_valid && !credit && c % 3 == 0;
      sr = s_ready;
      @(negedge clk);
      if (s_valid && sr) idx++;
      n_checks++;
      if (input_valid !== m_valid || FIR_input !== m_fir || level !== 5'(q.size()) ||
          s_ready !== (q.size() < DEPTH) || (level == 16 && s_ready !== 0)) begin
        n_fail++;
        $display("FAIL back_to_back c%0d: valid=%b/%b fir=%h/%h level=%0d/%0d s_ready=%b",
                 c, input_valid, m_valid, FIR_input, m_fir, level, q.size(), s_ready);
      end
      if (level == 16) saw_full = 1;
      if (input_valid) got.push_back(FIR_input);
    end
    s_valid = 0;
    ready_for_input = 0;
    n_checks++;
    if (!saw_full || got.size() != 20) begin
      n_fail++;
      $display("FAIL back_to_back_count: saw_full=%b strobes=%0d want 1,20", saw_full, got.size());
    end
    for (int j = 0; j < got.size(); j++) begin
      n_checks++;
      if (got[j] !== 16'h0100 + 16'(j)) begin
        n_fail++;
        $display("FAIL order[%0d]: got %h want %h", j, got[j], 16'h0100 + 16'(j));
      end
    end
  endtask

  task automatic test_double_ready();
    repeat (2) @(negedge clk);
    s_valid = 1;
    s_data = 16'h0DD0;
    @(negedge clk);
    s_valid = 0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      ready_for_input = (i < 2);
      @(negedge clk);
      ready_for_input = 0;
      n_checks++;
      if (input_valid !== m_valid || err_proto !== m_err || input_valid !== (i == 0) ||
          (i == 0 && FIR_input !== 16'h0DD0) || (i >= 1 && err_proto !== 1)) begin
        n_fail++;
        $display("FAIL double_ready i%0d: valid=%b/%b err=%b/%b fir=%h", i, input_valid, m_valid, err_proto, m_err, FIR_input);
      end
    end
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    n_checks++;
    if (err_proto !== 0) begin
      n_fail++;
      $display("FAIL err_clr: got %b want 0", err_proto);
    end
    s_valid = 1;
    s_data = 16'h0EE0;
    @(negedge clk);
    s_valid = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      ready_for_input = (i < 2);
      err_clr = (i >= 1);
      @(negedge clk);
      ready_for_input = 0;
      err_clr = 0;
      n_checks++;
      if (err_proto !== m_err || err_proto !== (i == 1)) begin
        n_fail++;
        $display("FAIL err_set_wins i%0d: got %b model %b", i, err_proto, m_err);
      end
    end
  endtask

  task automatic test_flush();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      s_valid = 1;
      s_data = 16'h0601 + 16'(k);
      @(negedge clk);
    end
    s_valid = 0;
    @(negedge clk);
    flush = 1;
    ready_for_input = 1;
    @(negedge clk);
    flush = 0;
    ready_for_input = 0;
    n_checks++;
    if (input_valid !== 1 || FIR_input !== 16'h0601 || level !== 0 || level !== 5'(q.size())) begin
      n_fail++;
      $display("FAIL flush_pop: valid=%b fir=%h level=%0d want 1,0601,0", input_valid, FIR_input, level);
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      ready_for_input = (i == 0);
      s_valid = (i == 6);
      s_data = 16'h0699;
      @(negedge clk);
      ready_for_input = 0;
      s_valid = 0;
      n_checks++;
      if (input_valid !== m_valid || FIR_input !== m_fir || input_valid !== (i == 7)) begin
        n_fail++;
        $display("FAIL flush_credit i%0d: valid=%b/%b fir=%h/%h", i, input_valid, m_valid, FIR_input, m_fir);
      end
    end
  endtask

  task automatic test_random();
    repeat (2) @(negedge clk);
    for (int c = 0; c < 800; c++) begin
      s_valid = $urandom_range(0, 2) != 0;
      s_data = 16'($urandom);
      ready_for_input = $urandom_range(0, 3) == 0 && ((!m_valid && !credit) || $urandom_range(0, 7) == 0);
      flush = $urandom_range(0, 39) == 0;
      err_clr = $urandom_range(0, 15) == 0;
      @(negedge clk);
      n_checks++;
      if (input_valid !== m_valid || FIR_input !== m_fir || level !== 5'(q.size()) ||
          s_ready !== (q.size() < DEPTH) || issued_count !== m_count || err_proto !== m_err) begin
        n_fail++;
        $display("FAIL random c%0d: valid=%b/%b fir=%h/%h level=%0d/%0d s_ready=%b cnt=%0d/%0d err=%b/%b",
                 c, input_valid, m_valid, FIR_input, m_fir, level, q.size(), s_ready,
                 issued_count, m_count, err_proto, m_err);
      end
    end
    s_valid = 0;
    ready_for_input = 0;
    flush = 0;
    err_clr = 0;
  endtask

  task automatic test_start_credit();
    @(negedge clk);
    reset2 = 1;
    s2_valid = 1;
    s2_data = 16'h1234;
    @(negedge clk);
    s2_valid = 0;
    @(negedge clk);
    n_checks++;
    if (valid2 !== 1 || fir2 !== 16'h1234) begin
      n_fail++;
      $display("FAIL start_credit: valid=%b fir=%h want 1,1234", valid2, fir2);
    end
    for (int k = 0; k < 5; k++) begin
      s2_valid = 1;
      s2_data = 16'h0500 + 16'(k);
      @(negedge clk);
    end
    s2_valid = 0;
    n_checks++;
    if (level2 !== 5 || count2 !== 1) begin
      n_fail++;
      $display("FAIL sc_queued: level=%0d cnt=%0d want 5,1", level2, count2);
    end
    rfi2 = 1;
    @(negedge clk);
    rfi2 = 0;
    n_checks++;
    if (valid2 !== 1 || fir2 !== 16'h0500) begin
      n_fail++;
      $display("FAIL sc_inflight: valid=%b fir=%h want 1,0500", valid2, fir2);
    end
    #2 reset2 = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (fir2 !== 0 || valid2 !== 0 || level2 !== 0 || count2 !== 0 || err2 !== 0 || s2_ready !== 1) begin
        n_fail++;
        $display("FAIL sc_midreset i%0d: fir=%h valid=%b level=%0d cnt=%0d err=%b s_ready=%b",
                 i, fir2, valid2, level2, count2, err2, s2_ready);
      end
      @(negedge clk);
    end
    reset2 = 1;
    s2_valid = 1;
    s2_data = 16'h0055;
    @(negedge clk);
    s2_valid = 0;
    @(negedge clk);
    n_checks++;
    if (valid2 !== 1 || fir2 !== 16'h0055) begin
      n_fail++;
      $display("FAIL sc_after_reset: valid=%b fir=%h want 1,0055", valid2, fir2);
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_empty_credit();
    test_back_to_back();
    test_double_ready();
    test_flush();
    test_random();
    test_start_credit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
